// File: rtl/axis_num_gen_pkg.sv
// ============================================================================
//  Module   : axis_num_gen_pkg
//  Brief    : Shared types and LFSR step function for the AXIS number generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_num_gen_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } gen_state_t;

  // Feedback tap masks, bit i set means state bit i feeds the XOR.
  localparam logic [31:0] c_taps_8  = 32'h0000_00B8;
  localparam logic [31:0] c_taps_16 = 32'h0000_B400;
  localparam logic [31:0] c_taps_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input int width);
    logic [31:0] taps;
    logic [31:0] mask;
    logic        fb;
    case (width)
      8:       begin taps = c_taps_8;  mask = 32'h0000_00FF; end
      16:      begin taps = c_taps_16; mask = 32'h0000_FFFF; end
      default: begin taps = c_taps_32; mask = 32'hFFFF_FFFF; end
    endcase
    fb = ^(state & taps);
    return ((state << 1) | {31'b0, fb}) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
//  Module   : lfsr_gen
//  Brief    : Fibonacci shift-left LFSR that steps once per cycle with i_en high.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_gen
  import axis_num_gen_pkg::*;
#(
  parameter int          DW   = 16,
  parameter logic [31:0] SEED = 32'h0000_ACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [DW-1:0] o_state
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  localparam logic [DW-1:0] c_seed_raw = SEED[DW-1:0];
  localparam logic [DW-1:0] c_seed     = (c_seed_raw == '0) ? DW'(1) : c_seed_raw;

  logic [DW-1:0] r_state;
  logic [31:0]   w_next32;

  assign w_next32 = lfsr_next(32'(r_state), DW);
  assign o_state  = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_seed;
    end else if (i_en) begin
      r_state <= w_next32[DW-1:0];
    end
  end

  generate
    if (DW < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_next32[31:DW];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/axis_lfsr_num_gen.sv
// ============================================================================
//  Module   : axis_lfsr_num_gen
//  Brief    : NoC traffic endpoint: sends one LFSR packet per START, counts RX.
//             Macro AXIS_TID_EN adds TID ports on both AXIS interfaces.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_lfsr_num_gen
  import axis_num_gen_pkg::*;
#(
  parameter int          TDATAW       = 32,
  parameter int          TDESTW       = 4,
  parameter int          TIDW         = 4,
  parameter int          LFSR_DW      = 16,
  parameter logic [31:0] LFSR_DEFAULT = 32'h0000_ACE1,
  parameter int          PKT_LEN      = 4,
  parameter int          DEST         = 1,
  parameter int          SRC_ID       = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
`ifdef AXIS_TID_EN
  output logic [TIDW-1:0]   AXIS_M_TID,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  output logic [TIDW-1:0]   RX_LAST_TID,
`endif
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic [15:0]       RX_BEATS,
  output logic [15:0]       RX_PKTS,
  output logic [TDATAW-1:0] RX_LAST_DATA
);

  localparam int                c_cntw = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [c_cntw-1:0] c_last = c_cntw'(PKT_LEN - 1);
  localparam logic [TDESTW-1:0] c_dest = TDESTW'(DEST);

  gen_state_t          r_state;
  logic [c_cntw-1:0]   r_cnt;
  logic [c_cntw-1:0]   w_cnt_inc;
  logic                r_tvalid;
  logic                r_tlast;
  logic                r_busy;
  logic [TDATAW-1:0]   r_tdata;
  logic [TDESTW-1:0]   r_tdest;
  logic                w_m_hs;

  logic [LFSR_DW-1:0]  w_lfsr_state;
  logic [31:0]         w_cur32;
  logic [31:0]         w_nxt32;
  logic [TDATAW-1:0]   w_cur_ext;
  logic [TDATAW-1:0]   w_nxt_ext;

  logic                r_s_tready;
  logic                w_s_hs;
  logic [15:0]         r_rx_beats;
  logic [15:0]         r_rx_pkts;
  logic [TDATAW-1:0]   r_rx_last_data;

  assign w_m_hs    = r_tvalid & AXIS_M_TREADY;
  assign w_s_hs    = AXIS_S_TVALID & r_s_tready;
  assign w_cnt_inc = r_cnt + c_cntw'(1);

  lfsr_gen #(
    .DW   (LFSR_DW),
    .SEED (LFSR_DEFAULT)
  ) u_lfsr (
    .clk     (CLK),
    .rst     (RST),
    .i_en    (w_m_hs),
    .o_state (w_lfsr_state)
  );

  // The word after a handshake is the LFSR's next state, loaded alongside it.
  assign w_cur32 = 32'(w_lfsr_state);
  assign w_nxt32 = lfsr_next(w_cur32, LFSR_DW);

  generate
    if (TDATAW > 32) begin : g_data_pad
      assign w_cur_ext = {{(TDATAW-32){1'b0}}, w_cur32};
      assign w_nxt_ext = {{(TDATAW-32){1'b0}}, w_nxt32};
    end else begin : g_data_slice
      assign w_cur_ext = w_cur32[TDATAW-1:0];
      assign w_nxt_ext = w_nxt32[TDATAW-1:0];
      if (TDATAW < 32) begin : g_slice_unused
        logic w_unused_hi;
        assign w_unused_hi = ^{w_cur32[31:TDATAW], w_nxt32[31:TDATAW]};
      end
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_busy   <= 1'b0;
      r_tdata  <= '0;
      r_tdest  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_state  <= SEND;
            r_cnt    <= '0;
            r_tvalid <= 1'b1;
            r_busy   <= 1'b1;
            r_tlast  <= (PKT_LEN == 1);
            r_tdata  <= w_cur_ext;
            r_tdest  <= c_dest;
          end
        end
        SEND: begin
          if (w_m_hs) begin
            if (r_tlast) begin
              r_state  <= IDLE;
              r_tvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_tlast  <= 1'b0;
            end else begin
              r_cnt   <= w_cnt_inc;
              r_tlast <= (w_cnt_inc == c_last);
              r_tdata <= w_nxt_ext;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s_tready     <= 1'b0;
      r_rx_beats     <= '0;
      r_rx_pkts      <= '0;
      r_rx_last_data <= '0;
    end else begin
      r_s_tready <= 1'b1;
      if (w_s_hs) begin
        r_rx_beats     <= r_rx_beats + 16'd1;
        r_rx_last_data <= AXIS_S_TDATA;
        if (AXIS_S_TLAST) begin
          r_rx_pkts <= r_rx_pkts + 16'd1;
        end
      end
    end
  end

`ifdef AXIS_TID_EN
  localparam logic [TIDW-1:0] c_tid = TIDW'(SRC_ID);

  logic [TIDW-1:0] r_tid;
  logic [TIDW-1:0] r_rx_last_tid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tid         <= '0;
      r_rx_last_tid <= '0;
    end else begin
      if (r_state == IDLE && START) begin
        r_tid <= c_tid;
      end
      if (w_s_hs) begin
        r_rx_last_tid <= AXIS_S_TID;
      end
    end
  end

  assign AXIS_M_TID  = r_tid;
  assign RX_LAST_TID = r_rx_last_tid;
`endif

  logic w_unused;
  assign w_unused = ^{AXIS_S_TDEST, TIDW[0], SRC_ID[0]};

  assign BUSY          = r_busy;
  assign AXIS_M_TVALID = r_tvalid;
  assign AXIS_M_TDATA  = r_tdata;
  assign AXIS_M_TLAST  = r_tlast;
  assign AXIS_M_TDEST  = r_tdest;
  assign AXIS_S_TREADY = r_s_tready;
  assign RX_BEATS      = r_rx_beats;
  assign RX_PKTS       = r_rx_pkts;
  assign RX_LAST_DATA  = r_rx_last_data;

endmodule

`default_nettype wire

// File: tb/tb_axis_lfsr_num_gen.sv
// ============================================================================
//  Module   : tb_axis_lfsr_num_gen
//  Brief    : Scoreboard bench for axis_lfsr_num_gen plus a PKT_LEN=1 loopback.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_lfsr_num_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [3:0]  m_tdest;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [3:0]  s_tdest;
  logic [15:0] rx_beats;
  logic [15:0] rx_pkts;
  logic [31:0] rx_last_data;

  logic        l_start;
  logic        l_busy;
  logic        l_tvalid;
  logic        l_tready;
  logic [31:0] l_tdata;
  logic        l_tlast;
  logic [3:0]  l_tdest;
  logic [15:0] l_rx_beats;
  logic [15:0] l_rx_pkts;
  logic [31:0] l_rx_last_data;

`ifdef AXIS_TID_EN
  logic [3:0] m_tid;
  logic [3:0] rx_last_tid;
  logic [3:0] l_tid;
  logic [3:0] l_rx_last_tid;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  axis_lfsr_num_gen u_dut (
    .CLK           (clk),
    .RST           (rst),
    .START         (start),
    .BUSY          (busy),
    .AXIS_M_TVALID (m_tvalid),
    .AXIS_M_TREADY (m_tready),
    .AXIS_M_TDATA  (m_tdata),
    .AXIS_M_TLAST  (m_tlast),
    .AXIS_M_TDEST  (m_tdest),
`ifdef AXIS_TID_EN
    .AXIS_M_TID    (m_tid),
    .AXIS_S_TID    (4'd0),
    .RX_LAST_TID   (rx_last_tid),
`endif
    .AXIS_S_TVALID (s_tvalid),
    .AXIS_S_TREADY (s_tready),
    .AXIS_S_TDATA  (s_tdata),
    .AXIS_S_TLAST  (s_tlast),
    .AXIS_S_TDEST  (s_tdest),
    .RX_BEATS      (rx_beats),
    .RX_PKTS       (rx_pkts),
    .RX_LAST_DATA  (rx_last_data)
  );

  // Master looped straight back into its own slave port.
  axis_lfsr_num_gen #(
    .PKT_LEN (1),
    .SRC_ID  (5)
  ) u_loop (
    .CLK           (clk),
    .RST           (rst),
    .START         (l_start),
    .BUSY          (l_busy),
    .AXIS_M_TVALID (l_tvalid),
    .AXIS_M_TREADY (l_tready),
    .AXIS_M_TDATA  (l_tdata),
    .AXIS_M_TLAST  (l_tlast),
    .AXIS_M_TDEST  (l_tdest),
`ifdef AXIS_TID_EN
    .AXIS_M_TID    (l_tid),
    .AXIS_S_TID    (l_tid),
    .RX_LAST_TID   (l_rx_last_tid),
`endif
    .AXIS_S_TVALID (l_tvalid),
    .AXIS_S_TREADY (l_tready),
    .AXIS_S_TDATA  (l_tdata),
    .AXIS_S_TLAST  (l_tlast),
    .AXIS_S_TDEST  (l_tdest),
    .RX_BEATS      (l_rx_beats),
    .RX_PKTS       (l_rx_pkts),
    .RX_LAST_DATA  (l_rx_last_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
    exp_q.push_back('{data: {16'h0, w0}, last: 1'b0, dest: 4'd1});
    exp_q.push_back('{data: {16'h0, w1}, last: 1'b0, dest: 4'd1});
    exp_q.push_back('{data: {16'h0, w2}, last: 1'b0, dest: 4'd1});
    exp_q.push_back('{data: {16'h0, w3}, last: 1'b1, dest: 4'd1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    check("tvalid_before_start", 32'(m_tvalid), 32'd0);
    tick();
    start = 1'b0;
    check("tvalid_latency", 32'(m_tvalid), 32'd1);
    check("busy_on_send", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every accepted master beat is matched in order.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got %h expected none", m_tdata);
      end else begin
        e = exp_q.pop_front();
        check("m_tdata", m_tdata, e.data);
        check("m_tlast", 32'(m_tlast), 32'(e.last));
        check("m_tdest", 32'(m_tdest), 32'(e.dest));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [3:0] pat;
    pat      = 4'b1001;
    rst      = 1'b1;
    start    = 1'b0;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tdest  = '0;
    l_start  = 1'b0;

    repeat (3) tick();
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_rx_beats", 32'(rx_beats), 32'd0);
    check("rst_rx_last_data", rx_last_data, 32'd0);
    rst = 1'b0;
    tick();
    check("s_tready_after_rst", 32'(s_tready), 32'd1);

    // Packet 1: free-flowing sink.
    m_tready = 1'b1;
    push_pkt(16'hACE1, 16'h59C3, 16'hB387, 16'h670F);
    pulse_start();
    wait_idle(20, "pkt1_idle");

    // Packet 2: continuation of the sequence under backpressure, START mid-send.
    m_tready = 1'b0;
    tick();
    push_pkt(16'hCE1E, 16'h9C3C, 16'h3879, 16'h70F2);
    pulse_start();
    for (int i = 0; i < 40 && busy; i++) begin
      m_tready = pat[i % 4];
      start    = (i == 2);
      tick();
    end
    start    = 1'b0;
    m_tready = 1'b1;
    check("pkt2_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    check("no_extra_pkt", 32'(m_tvalid), 32'd0);

    // Slave sink: two 3-beat packets with an idle gap carrying junk.
    for (int i = 1; i <= 6; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(i);
      s_tlast  = (i % 3 == 0);
      check("s_tready_held", 32'(s_tready), 32'd1);
      tick();
      if (i == 3) begin
        s_tvalid = 1'b0;
        s_tdata  = 32'd99;
        s_tlast  = 1'b1;
        tick();
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tick();
    check("rx_beats", 32'(rx_beats), 32'd6);
    check("rx_pkts", 32'(rx_pkts), 32'd2);
    check("rx_last_data", rx_last_data, 32'd6);

    // Reset mid-packet: first word E1E4 goes out, then abort while stalled.
    m_tready = 1'b0;
    exp_q.push_back('{data: 32'h0000_E1E4, last: 1'b0, dest: 4'd1});
    pulse_start();
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    tick();
    check("stall_tvalid", 32'(m_tvalid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rx_beats", 32'(rx_beats), 32'd0);
    check("async_rst_rx_pkts", 32'(rx_pkts), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    m_tready = 1'b1;
    push_pkt(16'hACE1, 16'h59C3, 16'hB387, 16'h670F);
    pulse_start();
    wait_idle(20, "pkt3_idle");

    // Loopback instance, single-word packets.
    l_start = 1'b1;
    tick();
    l_start = 1'b0;
    repeat (4) tick();
    check("loop_rx_pkts", 32'(l_rx_pkts), 32'd1);
    check("loop_rx_beats", 32'(l_rx_beats), 32'd1);
    check("loop_rx_last_data", l_rx_last_data, 32'h0000_ACE1);
    check("loop_busy", 32'(l_busy), 32'd0);
`ifdef AXIS_TID_EN
    check("loop_rx_last_tid", 32'(l_rx_last_tid), 32'd5);
`endif

    repeat (2) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
